mem_addr_sel: RTL
=================

// Module: mem_addr_sel
// PURPOSE
// - Registered memory-address selector for the multicycle datapath; next generation of the address-source mux.
// - Selects one of NUM_SRC packed address sources into a held address register.
// - Adds a built-in exception-vector fetch sequencer: reads VEC_BYTES bytes from VEC_BASE+cause*VEC_BYTES,
//   assembles the handler address, and owns the memory address while it runs.
// PARAMETERS
// - ADDR_W    32   width of address sources, mem_addr and vec_handler
// - NUM_SRC   3    number of address sources (0=regA, 1=PC, 2=ALUout by convention)
// - SEL_W     3    width of sel
// - VEC_BASE  253  byte address of cause-0 vector
// - NUM_CAUSE 3    number of valid exception causes
// - VEC_BYTES 1    bytes per vector, little-endian, 1..ADDR_W/8
// - MEM_LAT   1    memory read latency in cycles, >=1
// PORTS
// - clk          in   1                clock, rising edge
// - reset        in   1                asynchronous, active-low reset
// - sel          in   SEL_W            source select, sampled when addr_we=1
// - src_data     in   NUM_SRC*ADDR_W   packed sources; source i = src_data[i*ADDR_W +: ADDR_W]
// - addr_we      in   1                load mem_addr from selected source
// - vec_start    in   1                start vector fetch, 1-cycle request
// - vec_cause    in   2                exception cause index
// - mem_rdata    in   8                memory read byte
// - mem_addr     out  ADDR_W           registered memory address
// - vec_busy     out  1                sequencer active; addr_we ignored
// - vec_done     out  1                1-cycle pulse: vec_handler valid
// - vec_handler  out  ADDR_W           assembled handler address, held until next done
// - sel_err      out  1                1-cycle pulse: illegal sel or cause
// - addr_misalign out 1                see CONFIGURATION
// BEHAVIOUR
// - Reset (reset=0, async): every output 0, FSM to IDLE, byte counter and wait counter 0. Applies mid-sequence.
// - Normal load, IDLE only: addr_we=1 and sel<NUM_SRC -> mem_addr=src[sel] after the next edge (latency 1).
//   addr_we=1 and sel>=NUM_SRC -> mem_addr held, sel_err=1 for one cycle. addr_we=0 -> mem_addr held.
// - FSM states: IDLE, ISSUE, WAIT, DONE.
// - IDLE + vec_start, vec_cause<NUM_CAUSE -> ISSUE:
//   mem_addr=VEC_BASE+cause*VEC_BYTES, byte count=0, vec_busy=1.
// - IDLE + vec_start, vec_cause>=NUM_CAUSE -> stay IDLE, sel_err pulse, mem_addr unchanged.
// - vec_start and addr_we in the same cycle: vec_start wins; the load is dropped, no sel_err for sel.
// - ISSUE (1 cycle) -> WAIT, wait count=MEM_LAT-1.
// - WAIT: decrement the count; when it is 0, capture mem_rdata into byte[count] of the assembly register.
//   - Last byte -> DONE.
//   - Otherwise mem_addr+=1 and go to ISSUE.
// - DONE (1 cycle): vec_done=1, vec_handler=assembled value (upper unfetched bits 0), vec_busy=0 -> IDLE.
// - mem_addr keeps the last vector byte address after the sequence.
// - While vec_busy=1: vec_start, addr_we and sel are ignored; sel_err is not raised.
// - Total: VEC_BYTES*(MEM_LAT+1) busy cycles, plus the DONE cycle.
// - Address arithmetic is modulo 2^ADDR_W (wraps).
// CONFIGURATION
// - MEM_ADDR_MISALIGN_EN defined: addr_misalign is a registered flag, updated on every accepted normal load.
//   It is 1 when the loaded mem_addr[1:0]!=0; vector fetches clear it.
// - MEM_ADDR_MISALIGN_EN undefined: addr_misalign is tied to 0 and has no added logic.
// STRUCTURE
// - Package mem_addr_pkg: FSM state typedef (IDLE/ISSUE/WAIT/DONE) and source index constants
//   SRC_REGA/SRC_PC/SRC_ALUOUT.
//   It also holds default VEC_BASE=253.
// - Sub-module vec_fetch_fsm: sequencer (state, wait counter, byte counter, assembly register).
//   Top level keeps the select/load path and the mem_addr register.
// TESTING
// - Reset mid-fetch: drop reset in WAIT -> all outputs 0 immediately; IDLE after release.
// - Load: src={ALUout=0x40, PC=0x100, regA=0x8}, sel=1, addr_we=1 -> mem_addr=0x100 next cycle.
//   Then sel=5 -> mem_addr stays 0x100 and sel_err pulses.
// - Vector, defaults: cause=1, start at cycle 0 -> mem_addr=254 in cycles 1-2.
//   mem_rdata=0x7C in cycle 2 -> vec_done=1 and vec_handler=0x7C in cycle 3.
// - VEC_BYTES=4, MEM_LAT=2, cause=0, bytes 0x11,0x22,0x33,0x44 -> addresses 253..256.
//   vec_handler=0x44332211 with vec_done at cycle 13.
// - Collisions: vec_start with addr_we=1 sel=0 -> fetch runs, mem_addr not loaded from regA.
//   vec_start while busy is ignored; cause=3 gives sel_err and no busy.
// - MEM_ADDR_MISALIGN_EN: load 0x102 -> addr_misalign=1; load 0x104 -> 0. Without the macro it stays 0.

Source files
------------

// File: rtl/mem_addr_pkg.sv
// Shared types and constants for the memory-address selector and its vector-fetch sequencer.
package mem_addr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } vec_state_e;

    localparam int unsigned SRC_REGA         = 0;
    localparam int unsigned SRC_PC           = 1;
    localparam int unsigned SRC_ALUOUT       = 2;
    localparam int unsigned VEC_BASE_DEFAULT = 253;

endpackage

// File: rtl/mem_addr_sel_if.sv
// Bus bundle between the datapath controller (master) and the address selector (slave).
interface mem_addr_sel_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned SEL_W   = 3
);
    logic [SEL_W-1:0]          sel;
    logic [NUM_SRC*ADDR_W-1:0] src_data;
    logic                      addr_we;
    logic                      vec_start;
    logic [1:0]                vec_cause;
    logic [7:0]                mem_rdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      vec_busy;
    logic                      vec_done;
    logic [ADDR_W-1:0]         vec_handler;
    logic                      sel_err;
    logic                      addr_misalign;

    modport master (
        output sel, src_data, addr_we, vec_start, vec_cause, mem_rdata,
        input  mem_addr, vec_busy, vec_done, vec_handler, sel_err, addr_misalign
    );

    modport slave (
        input  sel, src_data, addr_we, vec_start, vec_cause, mem_rdata,
        output mem_addr, vec_busy, vec_done, vec_handler, sel_err, addr_misalign
    );
endinterface

// File: rtl/mem_addr_sel_vec_fetch_fsm.sv
// Exception-vector fetch sequencer: issues byte reads, waits MEM_LAT cycles per byte,
// and assembles the little-endian handler address.
module vec_fetch_fsm
    import mem_addr_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NUM_CAUSE = 3,
    parameter int unsigned VEC_BYTES = 1,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vec_start,
    input  logic [1:0]        vec_cause,
    input  logic [7:0]        mem_rdata,
    output logic              start_ok_c,
    output logic              cause_err_c,
    output logic              addr_inc_c,
    output logic              idle_c,
    output logic              vec_busy,
    output logic              vec_done,
    output logic [ADDR_W-1:0] vec_handler
);

    localparam int unsigned BCNT_W = (VEC_BYTES > 1) ? $clog2(VEC_BYTES) : 1;
    localparam int unsigned WCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    vec_state_e        state_q, state_n;
    logic [WCNT_W-1:0] wcnt_q, wcnt_n;
    logic [BCNT_W-1:0] bcnt_q, bcnt_n;
    logic [ADDR_W-1:0] asm_q, asm_n;

    assign idle_c = (state_q == IDLE);

    // Next-state, counters and assembly register.
    always_comb begin
        state_n     = state_q;
        wcnt_n      = wcnt_q;
        bcnt_n      = bcnt_q;
        asm_n       = asm_q;
        start_ok_c  = 1'b0;
        cause_err_c = 1'b0;
        addr_inc_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (vec_start) begin
                    if (32'(vec_cause) < NUM_CAUSE) begin
                        start_ok_c = 1'b1;
                        state_n    = ISSUE;
                        bcnt_n     = '0;
                        asm_n      = '0;
                    end else begin
                        cause_err_c = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_n = WAIT;
                wcnt_n  = WCNT_W'(MEM_LAT - 1);
            end
            WAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_n = wcnt_q - 1'b1;
                end else begin
                    asm_n[32'(bcnt_q)*8 +: 8] = mem_rdata;
                    if (bcnt_q == BCNT_W'(VEC_BYTES - 1)) begin
                        state_n = DONE;
                    end else begin
                        bcnt_n     = bcnt_q + 1'b1;
                        addr_inc_c = 1'b1;
                        state_n    = ISSUE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and registered status outputs, derived from the upcoming state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            bcnt_q      <= '0;
            asm_q       <= '0;
            vec_busy    <= 1'b0;
            vec_done    <= 1'b0;
            vec_handler <= '0;
        end else begin
            state_q  <= state_n;
            wcnt_q   <= wcnt_n;
            bcnt_q   <= bcnt_n;
            asm_q    <= asm_n;
            vec_busy <= (state_n == ISSUE) || (state_n == WAIT);
            vec_done <= (state_n == DONE);
            if ((state_q == WAIT) && (state_n == DONE)) begin
                vec_handler <= asm_n;
            end
        end
    end

endmodule

// File: rtl/mem_addr_sel.sv
// Registered memory-address selector with built-in exception-vector fetch.
// Optional feature macro: MEM_ADDR_MISALIGN_EN (registered misalignment flag on normal loads).
module mem_addr_sel
    import mem_addr_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NUM_SRC   = 3,
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned VEC_BASE  = VEC_BASE_DEFAULT,
    parameter int unsigned NUM_CAUSE = 3,
    parameter int unsigned VEC_BYTES = 1,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_addr_sel_if.slave  bus
);

    logic              start_ok_c, cause_err_c, addr_inc_c, idle_c;
    logic              load_ok_c, sel_ok_c;
    logic [ADDR_W-1:0] sel_addr_c, vec_addr_c;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic              sel_err_q, sel_err_n;

    vec_fetch_fsm #(
        .ADDR_W    (ADDR_W),
        .NUM_CAUSE (NUM_CAUSE),
        .VEC_BYTES (VEC_BYTES),
        .MEM_LAT   (MEM_LAT)
    ) u_fsm (
        .clk         (clk),
        .reset       (reset),
        .vec_start   (bus.vec_start),
        .vec_cause   (bus.vec_cause),
        .mem_rdata   (bus.mem_rdata),
        .start_ok_c  (start_ok_c),
        .cause_err_c (cause_err_c),
        .addr_inc_c  (addr_inc_c),
        .idle_c      (idle_c),
        .vec_busy    (bus.vec_busy),
        .vec_done    (bus.vec_done),
        .vec_handler (bus.vec_handler)
    );

    // Source mux; out-of-range selects leave sel_ok_c low.
    always_comb begin
        sel_addr_c = '0;
        sel_ok_c   = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (32'(bus.sel) == i) begin
                sel_addr_c = bus.src_data[i*ADDR_W +: ADDR_W];
                sel_ok_c   = 1'b1;
            end
        end
    end

    assign vec_addr_c = ADDR_W'(VEC_BASE + 32'(bus.vec_cause) * VEC_BYTES);

    // The sequencer owns the address while running; a vec_start request always drops a same-cycle load.
    always_comb begin
        mem_addr_n = mem_addr_q;
        sel_err_n  = cause_err_c;
        load_ok_c  = 1'b0;
        if (start_ok_c) begin
            mem_addr_n = vec_addr_c;
        end else if (addr_inc_c) begin
            mem_addr_n = mem_addr_q + ADDR_W'(1);
        end else if (idle_c && bus.addr_we && !bus.vec_start) begin
            if (sel_ok_c) begin
                mem_addr_n = sel_addr_c;
                load_ok_c  = 1'b1;
            end else begin
                sel_err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr_q <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr_n;
            sel_err_q  <= sel_err_n;
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.sel_err  = sel_err_q;

`ifdef MEM_ADDR_MISALIGN_EN
    logic misalign_q;

    // Tracks word alignment of the last normal load; a vector fetch clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else if (load_ok_c) begin
            misalign_q <= (sel_addr_c[1:0] != 2'b00);
        end else if (start_ok_c) begin
            misalign_q <= 1'b0;
        end
    end

    assign bus.addr_misalign = misalign_q;
`else
    assign bus.addr_misalign = 1'b0;
`endif

endmodule
